// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: sequencing controller for the BRAM line-delay chain of the
// 5x5 convolution filter. Generates the shared cyclic BRAM address and the
// enable/write strobes from the {vs,hs,de} status bus. Measures the active
// line width and counts how many delayed lines hold consistent data.
// Optional build macro: WIDTH_LOCK_EN (adopt a new width only after two
// consecutive lines agree on it).
module line_buf_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        stat_in,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [CNT_W-1:0]  line_width_o,
  output logic [2:0]        lines_valid_o,
  output logic              win_valid_o,
  output logic [CNT_W-1:0]  col_o,
  output logic [CNT_W-1:0]  row_o,
  output logic              width_err_o
);

  localparam logic [2:0] DEPTH_V = 3'(DEPTH);
`ifdef WIDTH_LOCK_EN
  // Both agreeing lines were written at the same addresses, so both count.
  localparam logic [2:0] LOCK_LV = (DEPTH >= 2) ? 3'd2 : 3'(DEPTH);
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t              state_q, state_d;
  logic                de_q, vs_q;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    row_q, row_d, row_le;
  logic [2:0]          lv_q, lv_d, lv_le;
  logic [CNT_W-1:0]    lw_q, lw_d;
  logic                err_q, err_d;
  logic                win_q, win_d;
  logic [CNT_W-1:0]    cand_q, cand_d;
  logic                cand_vld_q, cand_vld_d;

  logic                de, vs, de_rise, de_fall, vs_rise, line_end;
  logic [CNT_W-1:0]    meas;
  logic                unused_hs;

  // hs carries no sequencing meaning here: the address must not jump on hs,
  // otherwise blanking would disturb the RAM contents.
  assign unused_hs = stat_in[1];
  assign de        = stat_in[0];
  assign vs        = stat_in[2];
  assign de_rise   = de & ~de_q;
  assign de_fall   = ~de & de_q;
  assign vs_rise   = vs & ~vs_q;
  assign line_end  = de_fall & (state_q != S_IDLE);
  assign meas      = CNT_W'(cnt_q) + CNT_W'(1);

  // Pixel counter / BRAM address: restart on de rise, advance on de, hold at top.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (de_rise) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (de) begin
      if (cnt_q == '1) sat_d = 1'b1;
      else             cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  // Line-end bookkeeping (width check, row and valid-line count), then vs clear.
  always_comb begin
    lw_d       = lw_q;
    lv_le      = lv_q;
    row_le     = row_q;
    err_d      = 1'b0;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    if (line_end) begin
      row_le = row_q + CNT_W'(1);
      if (sat_q) begin
        // Overlong line: RAM tail was overwritten in place, nothing usable.
        err_d      = 1'b1;
        lv_le      = '0;
        cand_vld_d = 1'b0;
      end else if (lw_q == '0) begin
        lw_d  = meas;
        lv_le = (lv_q == DEPTH_V) ? lv_q : lv_q + 3'd1;
      end else if (meas == lw_q) begin
        lv_le      = (lv_q == DEPTH_V) ? lv_q : lv_q + 3'd1;
        cand_vld_d = 1'b0;
      end else begin
        err_d = 1'b1;
`ifdef WIDTH_LOCK_EN
        if (cand_vld_q && (cand_q == meas)) begin
          lw_d       = meas;
          lv_le      = LOCK_LV;
          cand_vld_d = 1'b0;
        end else begin
          cand_d     = meas;
          cand_vld_d = 1'b1;
          lv_le      = '0;
        end
`else
        lw_d  = meas;
        lv_le = 3'd1;
`endif
      end
    end
    lv_d  = lv_le;
    row_d = row_le;
    if (vs_rise) begin
      lv_d       = '0;
      row_d      = '0;
      cand_vld_d = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: leave IDLE on vs, then RUN exactly while the window is full.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (vs_rise) state_d = S_FILL;
      S_FILL,
      S_RUN:   state_d = (lv_d == DEPTH_V) ? S_RUN : S_FILL;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: window valid only in RUN, column hidden while idle.
  always_comb begin
    win_d = (state_d == S_RUN) & de;
    col_d = (state_d == S_IDLE) ? '0 : CNT_W'(cnt_d);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q       <= 1'b0;
      vs_q       <= 1'b0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      lv_q       <= '0;
      lw_q       <= '0;
      err_q      <= 1'b0;
      win_q      <= 1'b0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
    end else begin
      de_q       <= de;
      vs_q       <= vs;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      col_q      <= col_d;
      row_q      <= row_d;
      lv_q       <= lv_d;
      lw_q       <= lw_d;
      err_q      <= err_d;
      win_q      <= win_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
    end
  end

  assign bram_addr_o   = cnt_q;
  assign bram_en_o     = de_q;
  assign bram_we_o     = de_q;
  assign line_width_o  = lw_q;
  assign lines_valid_o = lv_q;
  assign win_valid_o   = win_q;
  assign col_o         = col_q;
  assign row_o         = row_q;
  assign width_err_o   = err_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: reset/IDLE vector table, directed line sequences
// and a randomized status stream, all compared each cycle against a
// pixel-count reference model. Honors WIDTH_LOCK_EN when defined.
module tb_line_buf_ctrl;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 12;
  localparam int MAXA   = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        stat_in;
  logic [ADDR_W-1:0] bram_addr_o;
  logic              bram_en_o, bram_we_o;
  logic [CNT_W-1:0]  line_width_o;
  logic [2:0]        lines_valid_o;
  logic              win_valid_o;
  logic [CNT_W-1:0]  col_o, row_o;
  logic              width_err_o;

  line_buf_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stat_in(stat_in),
    .bram_addr_o(bram_addr_o), .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
    .line_width_o(line_width_o), .lines_valid_o(lines_valid_o),
    .win_valid_o(win_valid_o), .col_o(col_o), .row_o(row_o),
    .width_err_o(width_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_err, n_win, max_addr;

  // Reference model: pixels counted per line, rules applied at line/frame events.
  int m_pix, m_addr, m_width, m_lv, m_row, m_cand;
  bit m_act, m_candv, m_pde, m_pvs, m_err, m_en, m_win;

  task automatic mdl_reset();
    m_pix = 0; m_addr = 0; m_width = 0; m_lv = 0; m_row = 0; m_cand = 0;
    m_act = 0; m_candv = 0; m_pde = 0; m_pvs = 0; m_err = 0; m_en = 0; m_win = 0;
  endtask

  task automatic mdl_step(input bit v, input bit d);
    bit rd, fl, rv;
    rd = d && !m_pde;
    fl = !d && m_pde;
    rv = v && !m_pvs;
    m_err = 0;
    if (fl && m_act) begin
      m_row++;
      if (m_pix > MAXA + 1) begin
        m_err = 1; m_lv = 0; m_candv = 0;
      end else if (m_width == 0) begin
        m_width = m_pix; m_lv = (m_lv < DEPTH) ? m_lv + 1 : DEPTH;
      end else if (m_pix == m_width) begin
        m_lv = (m_lv < DEPTH) ? m_lv + 1 : DEPTH; m_candv = 0;
      end else begin
        m_err = 1;
`ifdef WIDTH_LOCK_EN
        if (m_candv && m_cand == m_pix) begin
          m_width = m_pix; m_lv = (DEPTH >= 2) ? 2 : DEPTH; m_candv = 0;
        end else begin
          m_cand = m_pix; m_candv = 1; m_lv = 0;
        end
`else
        m_width = m_pix; m_lv = 1;
`endif
      end
    end
    if (rv) begin m_act = 1; m_row = 0; m_lv = 0; m_candv = 0; end
    if (d) begin
      m_pix  = rd ? 1 : m_pix + 1;
      m_addr = (m_pix - 1 > MAXA) ? MAXA : m_pix - 1;
    end
    m_en  = d;
    m_win = m_act && (m_lv == DEPTH) && d;
    m_pde = d;
    m_pvs = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    int col;
    col = m_act ? m_addr : 0;
    total++;
    if ({bram_addr_o, bram_en_o, bram_we_o, line_width_o, lines_valid_o, win_valid_o,
         col_o, row_o, width_err_o} !==
        {ADDR_W'(m_addr), m_en, m_en, CNT_W'(m_width), 3'(m_lv), m_win,
         CNT_W'(col), CNT_W'(m_row), m_err}) begin
      bad++;
      $display("FAIL cyc@%0t addr=%0d/%0d en=%b/%b we=%b/%b lw=%0d/%0d lv=%0d/%0d win=%b/%b col=%0d/%0d row=%0d/%0d err=%b/%b (got/want)",
               $time, bram_addr_o, m_addr, bram_en_o, m_en, bram_we_o, m_en,
               line_width_o, m_width, lines_valid_o, m_lv, win_valid_o, m_win,
               col_o, col, row_o, m_row, width_err_o, m_err);
    end
  endtask

  task automatic cyc(input bit v, input bit h, input bit d);
    stat_in = {v, h, d};
    mdl_step(v, d);
    @(posedge clk); #1;
    n_err += int'(width_err_o);
    n_win += int'(win_valid_o);
    if (int'(bram_addr_o) > max_addr) max_addr = int'(bram_addr_o);
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stat_in = 3'b000;
    repeat (3) begin @(posedge clk); #1; end
    mdl_reset();
    cmp_model();
    rst = 1'b0;
  endtask

  task automatic line(input int w, input int blank);
    for (int i = 0; i < w; i++) cyc(0, 0, 1);
    for (int i = 0; i < blank; i++) cyc(0, (i < 2), 0);
  endtask

  task automatic vs_pulse();
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic clr_stats();
    n_err = 0; n_win = 0; max_addr = 0;
  endtask

  typedef struct {
    logic [2:0]        st;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  row;
    logic [2:0]        lv;
    logic [CNT_W-1:0]  lw;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3'b001, 1'b1, 11'd0, 12'd0, 3'd0, 12'd0};
    tbl[1] = '{3'b001, 1'b1, 11'd1, 12'd0, 3'd0, 12'd0};
    tbl[2] = '{3'b001, 1'b1, 11'd2, 12'd0, 3'd0, 12'd0};
    tbl[3] = '{3'b000, 1'b0, 11'd2, 12'd0, 3'd0, 12'd0};
    tbl[4] = '{3'b011, 1'b1, 11'd0, 12'd0, 3'd0, 12'd0};
    tbl[5] = '{3'b000, 1'b0, 11'd0, 12'd0, 3'd0, 12'd0};
    tbl[6] = '{3'b010, 1'b0, 11'd0, 12'd0, 3'd0, 12'd0};
    tbl[7] = '{3'b000, 1'b0, 11'd0, 12'd0, 3'd0, 12'd0};

    mdl_reset();
    clr_stats();
    do_reset();
    chk("rst_addr", 32'(bram_addr_o), 0);
    chk("rst_row", 32'(row_o), 0);

    // IDLE: de before any vs writes RAM but leaves frame state untouched.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st[2], tbl[i].st[1], tbl[i].st[0]);
      chk($sformatf("idle%0d_we", i), 32'(bram_we_o), 32'(tbl[i].we));
      chk($sformatf("idle%0d_addr", i), 32'(bram_addr_o), 32'(tbl[i].addr));
      chk($sformatf("idle%0d_row", i), 32'(row_o), 32'(tbl[i].row));
      chk($sformatf("idle%0d_lv", i), 32'(lines_valid_o), 32'(tbl[i].lv));
      chk($sformatf("idle%0d_lw", i), 32'(line_width_o), 32'(tbl[i].lw));
    end

    // Five 640-px lines after vs: window fills on line 5.
    vs_pulse();
    for (int k = 1; k <= 5; k++) begin
      clr_stats();
      line(640, 20);
      chk($sformatf("l%0d_lv", k), 32'(lines_valid_o), (k < 4) ? k : 4);
      chk($sformatf("l%0d_lw", k), 32'(line_width_o), 640);
      chk($sformatf("l%0d_maxaddr", k), max_addr, 639);
      chk($sformatf("l%0d_win", k), n_win, (k == 5) ? 640 : 0);
      chk($sformatf("l%0d_row", k), 32'(row_o), k);
    end

`ifdef WIDTH_LOCK_EN
    // Width lock: 640, 642, 642 -> errors on lines 2 and 3, adopt after line 3.
    clr_stats(); line(640, 20);
    chk("lk1_err", n_err, 0);
    clr_stats(); line(642, 20);
    chk("lk2_err", n_err, 1);
    chk("lk2_lw", 32'(line_width_o), 640);
    chk("lk2_lv", 32'(lines_valid_o), 0);
    clr_stats(); line(642, 20);
    chk("lk3_err", n_err, 1);
    chk("lk3_lw", 32'(line_width_o), 642);
    chk("lk3_lv", 32'(lines_valid_o), 2);
`else
    // Single mismatching line in RUN is adopted immediately.
    clr_stats(); line(642, 20);
    chk("mm_err", n_err, 1);
    chk("mm_lw", 32'(line_width_o), 642);
    chk("mm_lv", 32'(lines_valid_o), 1);
    clr_stats();
    for (int k = 0; k < 3; k++) line(642, 20);
    chk("mm_win3", n_win, 0);
    chk("mm_lv3", 32'(lines_valid_o), 4);
`endif

    // Get back to RUN, then vs during blanking clears the frame state.
    for (int k = 0; k < 4 && m_lv != DEPTH; k++) line(642, 20);
    chk("pre_vs_lv", 32'(lines_valid_o), 4);
    vs_pulse();
    chk("vs_row", 32'(row_o), 0);
    chk("vs_lv", 32'(lines_valid_o), 0);
    chk("vs_lw", 32'(line_width_o), 642);
    clr_stats(); line(642, 20);
    chk("vs_win", n_win, 0);

    // Overlong line saturates the address and flags an error.
    clr_stats(); line(2100, 20);
    chk("sat_maxaddr", max_addr, 2047);
    chk("sat_err", n_err, 1);
    chk("sat_lw", 32'(line_width_o), 642);
    chk("sat_lv", 32'(lines_valid_o), 0);

    // Randomized stream: vs pulses, mixed widths, vs coinciding with de fall, resets.
    for (int it = 0; it < 120; it++) begin
      int r, w;
      r = int'($urandom_range(0, 11));
      w = (r < 6) ? 16 : int'($urandom_range(2, 18));
      if (r == 0) vs_pulse();
      else if (r == 1) begin
        for (int i = 0; i < w; i++) cyc(0, 0, 1);
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
      end else if (r == 2) begin
        for (int i = 0; i < w; i++) cyc(0, 0, 1);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
      end else line(w, int'($urandom_range(1, 6)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
